dcache_controller: RTL and testbench

DCACHE_CONTROLLER -- requirements
Module: dcache_controller

---
 rtl/dcache_controller.sv | 120 ++++++++++++
 tb/tb_dcache_controller.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_controller.sv
// Direct-mapped write-back, write-allocate data cache controller.
// One CPU word port in front of a 256-bit line-wide memory port.
module dcache_controller #(
  parameter int LINES = 32,
  parameter int IDX_W = 5
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         cpu_req_i,
  input  logic         cpu_write_i,
  input  logic [31:0]  cpu_addr_i,
  input  logic [31:0]  cpu_data_i,
  output logic [31:0]  cpu_data_o,
  output logic         cpu_stall_o,
  output logic         mem_enable_o,
  output logic         mem_write_o,
  output logic [31:0]  mem_addr_o,
  output logic [255:0] mem_data_o,
  input  logic [255:0] mem_data_i,
  input  logic         mem_ack_i,
  output logic [1:0]   dbg_state_o
);

  localparam int TAG_W = 27 - IDX_W;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WRITEBACK = 2'd1;
  localparam logic [1:0] ALLOCATE  = 2'd2;
  localparam logic [1:0] FILL      = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [LINES-1:0] valid_q, dirty_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [255:0]     data_q [LINES];

  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] req_idx;
  logic [2:0]       req_word;
  logic [7:0]       word_lsb;
  logic             hit, store_hit, fill_en;
  logic             unused_addr_lsb;

  assign req_tag         = cpu_addr_i[31:5+IDX_W];
  assign req_idx         = cpu_addr_i[4+IDX_W:5];
  assign req_word        = cpu_addr_i[4:2];
  assign word_lsb        = {req_word, 5'b0};
  assign unused_addr_lsb = ^cpu_addr_i[1:0];

  assign hit         = cpu_req_i & (state_q == IDLE) & valid_q[req_idx] &
                       (tag_q[req_idx] == req_tag);
  assign store_hit   = hit & cpu_write_i;
  assign fill_en     = (state_q == FILL);
  assign cpu_stall_o = cpu_req_i & ~hit;
  assign cpu_data_o  = hit ? data_q[req_idx][word_lsb +: 32] : 32'd0;
  assign dbg_state_o = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (cpu_req_i && !hit) begin
          if (valid_q[req_idx] && dirty_q[req_idx]) state_d = WRITEBACK;
          else                                      state_d = ALLOCATE;
        end
      end
      WRITEBACK: if (mem_ack_i) state_d = ALLOCATE;
      ALLOCATE:  if (mem_ack_i) state_d = FILL;
      default:   state_d = IDLE;
    endcase
  end

  // Memory-side outputs decode from the registered state and the held CPU
  // address, so they stay constant for the whole transaction.
  always_comb begin
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = 32'd0;
    mem_data_o   = 256'd0;
    case (state_q)
      WRITEBACK: begin
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = {tag_q[req_idx], req_idx, 5'b0};
        mem_data_o   = data_q[req_idx];
      end
      ALLOCATE: begin
        mem_enable_o = 1'b1;
        mem_addr_o   = {req_tag, req_idx, 5'b0};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      if (fill_en) begin
        valid_q[req_idx] <= 1'b1;
        dirty_q[req_idx] <= 1'b0;
      end else if (store_hit) begin
        dirty_q[req_idx] <= 1'b1;
      end
    end
  end

  // Tag and data arrays carry no reset; valid bits alone qualify them.
  always_ff @(posedge clk_i) begin
    if (fill_en) begin
      tag_q[req_idx]  <= req_tag;
      data_q[req_idx] <= mem_data_i;
    end else if (store_hit) begin
      data_q[req_idx][word_lsb +: 32] <= cpu_data_i;
    end
  end

endmodule

// File: tb/tb_dcache_controller.sv
// Directed plus random bench for dcache_controller, with a line-memory
// responder and a direct-mapped cache reference model.
module tb_dcache_controller;

  localparam int LINES = 32;
  localparam int IDX_W = 5;

  typedef struct {
    logic         wr;
    logic [31:0]  addr;
    logic [255:0] data;
    int           ncyc;
    logic         stable;
  } txn_t;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         cpu_req_i, cpu_write_i;
  logic [31:0]  cpu_addr_i, cpu_data_i, cpu_data_o;
  logic         cpu_stall_o, mem_enable_o, mem_write_o, mem_ack_i;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o, mem_data_i;
  logic [1:0]   dbg_state_o;

  int n_assert = 0;
  int n_fail   = 0;
  int lat      = 8;

  logic [255:0] mem_arr [int unsigned];
  logic [255:0] ref_mem [int unsigned];
  txn_t         obs_q [$];
  txn_t         exp_q [$];
  logic [255:0] last_wb;
  logic [31:0]  last_word;

  logic         m_valid [LINES];
  logic         m_dirty [LINES];
  logic [21:0]  m_tag   [LINES];
  logic [255:0] m_line  [LINES];

  dcache_controller #(.LINES(LINES), .IDX_W(IDX_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .cpu_req_i(cpu_req_i), .cpu_write_i(cpu_write_i),
    .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o),
    .cpu_stall_o(cpu_stall_o), .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_data_i(mem_data_i),
    .mem_ack_i(mem_ack_i), .dbg_state_o(dbg_state_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [255:0] init_line(input int unsigned ln);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = (ln * 8 + w) * 32'h9E37_79B1 + 32'h1234;
    return l;
  endfunction

  function automatic logic [255:0] mem_read(input int unsigned ln);
    if (mem_arr.exists(ln)) return mem_arr[ln];
    return init_line(ln);
  endfunction

  function automatic logic [255:0] ref_read(input int unsigned ln);
    if (ref_mem.exists(ln)) return ref_mem[ln];
    return init_line(ln);
  endfunction

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory responder: acks after `lat` enable cycles, records each transaction.
  initial begin
    txn_t cur;
    int   cnt;
    cnt = 0;
    cur = '{default: '0};
    mem_ack_i  = 1'b0;
    mem_data_i = '0;
    forever begin
      @(posedge clk_i); #1;
      if (rst_i) begin
        cnt = 0;
        mem_ack_i = 1'b0;
      end else begin
        if (mem_ack_i) begin
          mem_ack_i = 1'b0;
          cnt = 0;
          if (!cur.wr) check("en_after_fetch_ack", mem_enable_o, 0);
        end
        if (mem_enable_o) begin
          if (cnt == 0) begin
            cur.wr = mem_write_o; cur.addr = mem_addr_o; cur.data = mem_data_o; cur.stable = 1'b1;
          end else if ({mem_write_o, mem_addr_o, mem_data_o} !== {cur.wr, cur.addr, cur.data}) begin
            cur.stable = 1'b0;
          end
          cnt++;
          if (cnt >= lat) begin
            cur.ncyc  = cnt;
            mem_ack_i = 1'b1;
            if (cur.wr) mem_arr[cur.addr >> 5] = cur.data;
            else        mem_data_i = mem_read(cur.addr >> 5);
            obs_q.push_back(cur);
          end
        end
      end
    end
  end

  task automatic model_reset();
    for (int i = 0; i < LINES; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic access(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input string tag);
    int unsigned idx, w, ln;
    int          exp_cyc, cyc;
    logic [21:0] t;
    txn_t        e, o;
    idx = (addr >> 5) % LINES;
    w   = (addr >> 2) % 8;
    ln  = addr >> 5;
    t   = addr[31:10];
    if (m_valid[idx] && m_tag[idx] == t) begin
      exp_cyc = 0;
    end else begin
      if (m_valid[idx] && m_dirty[idx]) begin
        e = '{wr: 1'b1, addr: {m_tag[idx], 5'(idx), 5'b0}, data: m_line[idx], ncyc: lat, stable: 1'b1};
        exp_q.push_back(e);
        ref_mem[e.addr >> 5] = m_line[idx];
        exp_cyc = 2 * lat + 2;
      end else begin
        exp_cyc = lat + 2;
      end
      e = '{wr: 1'b0, addr: ln << 5, data: '0, ncyc: lat, stable: 1'b1};
      exp_q.push_back(e);
      m_line[idx]  = ref_read(ln);
      m_valid[idx] = 1'b1;
      m_dirty[idx] = 1'b0;
      m_tag[idx]   = t;
    end

    @(negedge clk_i);
    cpu_req_i = 1'b1; cpu_write_i = wr; cpu_addr_i = addr; cpu_data_i = wdata;
    #1;
    cyc = 0;
    while (cpu_stall_o !== 1'b0 && cyc < 300) begin
      @(negedge clk_i);
      cyc++;
    end
    check({tag, "_latency"}, cyc, exp_cyc);
    last_word = cpu_data_o;
    if (!wr) check({tag, "_rdata"}, cpu_data_o, m_line[idx][w*32 +: 32]);
    @(negedge clk_i);
    cpu_req_i = 1'b0;

    check({tag, "_ntxn"}, obs_q.size(), exp_q.size());
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      check({tag, "_txn_wr"}, o.wr, e.wr);
      check({tag, "_txn_addr"}, o.addr, e.addr);
      check({tag, "_txn_data"}, o.data, e.data);
      check({tag, "_txn_cycles"}, o.ncyc, e.ncyc);
      check({tag, "_txn_stable"}, o.stable, 1'b1);
      if (o.wr) last_wb = o.data;
    end
    obs_q.delete();
    exp_q.delete();

    if (wr) begin
      m_line[idx][w*32 +: 32] = wdata;
      m_dirty[idx] = 1'b1;
    end
  endtask

  initial begin
    logic [255:0] l2;
    rst_i = 1'b1;
    cpu_req_i = 1'b0; cpu_write_i = 1'b0; cpu_addr_i = '0; cpu_data_i = '0;
    last_wb = '0; last_word = '0;
    l2 = init_line(2);
    l2[31:0] = 32'h1111_1111;
    mem_arr[2] = l2;
    ref_mem[2] = l2;
    model_reset();

    repeat (2) @(negedge clk_i);
    check("rst_mem_en", mem_enable_o, 0);
    check("rst_mem_wr", mem_write_o, 0);
    check("rst_mem_addr", mem_addr_o, 0);
    check("rst_mem_data", mem_data_o, 0);
    check("rst_stall", cpu_stall_o, 0);
    check("rst_cpu_data", cpu_data_o, 0);
    rst_i = 1'b0;
    @(negedge clk_i);
    check("idle_mem_en", mem_enable_o, 0);

    lat = 8;
    access(1'b0, 32'h0000_0040, 32'h0, "load_40_miss");
    check("load_40_word0", last_word, 32'h1111_1111);
    access(1'b1, 32'h0000_0044, 32'hDEAD_BEEF, "store_44_hit");
    access(1'b0, 32'h0000_0044, 32'h0, "load_44_hit");
    check("load_44_value", last_word, 32'hDEAD_BEEF);
    access(1'b0, 32'h0000_0440, 32'h0, "load_440_dirty");
    check("wb_40_word1", last_wb[63:32], 32'hDEAD_BEEF);
    access(1'b0, 32'h0000_0840, 32'h0, "load_840_clean");

    // Abort a fetch partway through ALLOCATE.
    @(negedge clk_i);
    cpu_req_i = 1'b1; cpu_write_i = 1'b0; cpu_addr_i = 32'h0000_0C80;
    repeat (3) @(negedge clk_i);
    check("alloc_en", mem_enable_o, 1);
    check("alloc_wr", mem_write_o, 0);
    check("alloc_addr", mem_addr_o, 32'h0000_0C80);
    rst_i = 1'b1;
    #1;
    check("abort_mem_en", mem_enable_o, 0);
    check("abort_mem_addr", mem_addr_o, 0);
    cpu_req_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
    check("abort_no_txn", obs_q.size(), 0);
    model_reset();
    access(1'b0, 32'h0000_0C80, 32'h0, "reload_after_abort");

    for (int i = 0; i < 60; i++) begin
      logic [31:0] a;
      lat = $urandom_range(2, 6);
      a = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 3) << 5) | ($urandom_range(0, 7) << 2);
      access(1'($urandom_range(0, 1)), a, $urandom, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
